// File: rtl/axil_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// FLUSH only exists when AXIL_CMD_MASTER_TIMEOUT_EN is defined.
package axil_cmd_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R,
    RSP
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    , FLUSH
`endif
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // States in which the master is waiting on the slave.
  function automatic logic is_wait_state(input state_t s);
    return (s == WR) || (s == WR_B) || (s == RD_AR) || (s == RD_R);
  endfunction

endpackage

// File: rtl/axil_cmd_watchdog.sv
// Per-transaction wait counter; expired flags the TIMEOUT_CYCLES-th waiting
// clock so the master can present the timeout response on the next one.
module axil_cmd_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count >= LAST);

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction,
// one response out. Optional watchdog/flush under AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  // command / response
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  // AXI4-Lite master
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  // debug
  output state_t                          dbg_state
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  // Handshake rule on every channel: a transfer happens on a rising clock edge
  // where valid and ready are both high; a raised valid (and its payload) is
  // held unchanged until that edge, and ready never gates valid.

  state_t          state, state_n;
  logic            aw_pend, w_pend, ar_pend;
  logic            aw_pend_n, w_pend_n, ar_pend_n;
  logic            bready_q, rready_q, cmd_ready_q, rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic [1:0]      rsp_resp_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic            write_q;
  logic            cmd_fire, b_fire, r_fire;
  logic            cap_b, cap_r;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign b_fire   = M_AXI_BVALID && bready_q;
  assign r_fire   = M_AXI_RVALID && rready_q;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  logic wd_expired;
  logic cap_to;
  logic timed_out_q;

  axil_cmd_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .clr     (cmd_fire),
    .en      (is_wait_state(state)),
    .expired (wd_expired)
  );
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    // pending valids retire on their own handshake regardless of state
    aw_pend_n = aw_pend && !M_AXI_AWREADY;
    w_pend_n  = w_pend && !M_AXI_WREADY;
    ar_pend_n = ar_pend && !M_AXI_ARREADY;
    cap_b     = 1'b0;
    cap_r     = 1'b0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    cap_to    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_n   = cmd_write ? WR : RD_AR;
          aw_pend_n = cmd_write;
          w_pend_n  = cmd_write;
          ar_pend_n = !cmd_write;
        end
      end
      WR: begin
        if (!aw_pend_n && !w_pend_n) state_n = WR_B;
      end
      WR_B: begin
        if (b_fire) begin
          cap_b   = 1'b1;
          state_n = RSP;
        end
      end
      RD_AR: begin
        if (!ar_pend_n) state_n = RD_R;
      end
      RD_R: begin
        if (r_fire) begin
          cap_r   = 1'b1;
          state_n = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
          state_n = timed_out_q ? FLUSH : IDLE;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      FLUSH: begin
        if (write_q ? b_fire : r_fire) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // a transaction completing on the expiry clock wins over the timeout
    if (wd_expired && (state_n != RSP)) begin
      cap_to  = 1'b1;
      state_n = RSP;
    end
`endif
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      ar_pend     <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
    end else begin
      aw_pend     <= aw_pend_n;
      w_pend      <= w_pend_n;
      ar_pend     <= ar_pend_n;
      cmd_ready_q <= (state_n == IDLE);
      rsp_valid_q <= (state_n == RSP);
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      bready_q    <= (state_n == WR_B) || ((state_n == FLUSH) && write_q);
      rready_q    <= (state_n == RD_R) || ((state_n == FLUSH) && !write_q);
`else
      bready_q    <= (state_n == WR_B);
      rready_q    <= (state_n == RD_R);
`endif
      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
      end
      if (cap_b) begin
        rsp_rdata_q <= '0;
        rsp_resp_q  <= M_AXI_BRESP;
      end else if (cap_r) begin
        rsp_rdata_q <= M_AXI_RDATA;
        rsp_resp_q  <= M_AXI_RRESP;
      end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      else if (cap_to) begin
        rsp_rdata_q <= '0;
        rsp_resp_q  <= RESP_SLVERR;
      end
`endif
    end
  end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      timed_out_q <= 1'b0;
    end else if (cmd_fire) begin
      timed_out_q <= 1'b0;
    end else if (cap_to) begin
      timed_out_q <= 1'b1;
    end
  end

  assign rsp_timeout = timed_out_q && rsp_valid_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_pend;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = w_pend;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = ar_pend;
  assign M_AXI_RREADY  = rready_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Self-checking bench for axil_cmd_master: behavioural AXI4-Lite slave,
// address-map reference model with expected-response queue, directed tests.
module tb_axil_cmd_master;
  import axil_cmd_master_pkg::*;

  localparam int W = 35;  // {rdata[31:0], resp[1:0], timeout}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic        rvalid = 1'b0, rready;
  state_t      dbg_state;

  axil_cmd_master #(
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (32),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .M_AXI_ACLK (clk), .M_AXI_ARESETN (rst_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .rsp_resp (rsp_resp), .rsp_timeout (rsp_timeout),
    .M_AXI_AWADDR (awaddr), .M_AXI_AWPROT (awprot), .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready), .M_AXI_WDATA (wdata), .M_AXI_WSTRB (wstrb),
    .M_AXI_WVALID (wvalid), .M_AXI_WREADY (wready), .M_AXI_BRESP (bresp),
    .M_AXI_BVALID (bvalid), .M_AXI_BREADY (bready), .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot), .M_AXI_ARVALID (arvalid), .M_AXI_ARREADY (arready),
    .M_AXI_RDATA (rdata), .M_AXI_RRESP (rresp), .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready), .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got cyc=%0d", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Address map: addr[9:8]==2 -> SLVERR, ==3 -> DECERR, else a 16-word
  // register file where word 0 always reads 0xDEADBEEF.
  logic [31:0] ref_mem[16];

  function automatic logic [W-1:0] model_cmd(input bit wr, input logic [31:0] addr,
                                             input logic [31:0] data, input logic [3:0] strb);
    logic [1:0]  resp;
    logic [31:0] rd;
    int          idx;
    idx  = int'(addr[5:2]);
    resp = (addr[9:8] >= 2'd2) ? addr[9:8] : 2'b00;
    rd   = 32'h0;
    if (resp == 2'b00) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      end else begin
        rd = (idx == 0) ? 32'hDEADBEEF : ref_mem[idx];
      end
    end
    return {rd, resp, 1'b0};
  endfunction

  // ---------------- behavioural AXI4-Lite slave ----------------
  logic [31:0] slv_mem[16];
  int          aw_delay = 0, w_delay = 0;
  bit          b_block = 0, r_block = 0;
  int          b_count = 0;
  bit          s_aw_got, s_w_got, s_b_pend, s_ar_got, s_r_pend;
  int          s_aw_wait, s_w_wait;
  logic [31:0] s_aw_addr, s_w_data, s_ar_addr, s_rdata;
  logic [3:0]  s_w_strb;
  logic [1:0]  s_bresp, s_rresp;

  initial begin
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = '0;
      ref_mem[i] = '0;
    end
    s_aw_got = 0; s_w_got = 0; s_b_pend = 0; s_ar_got = 0; s_r_pend = 0;
    s_aw_wait = 0; s_w_wait = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_aw_got = 0; s_w_got = 0; s_b_pend = 0; s_ar_got = 0; s_r_pend = 0;
        s_aw_wait = 0; s_w_wait = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        continue;
      end
      if (s_aw_got && s_w_got && !s_b_pend) begin
        s_bresp = (s_aw_addr[9:8] >= 2'd2) ? s_aw_addr[9:8] : 2'b00;
        if (s_bresp == 2'b00)
          for (int b = 0; b < 4; b++)
            if (s_w_strb[b]) slv_mem[s_aw_addr[5:2]][8*b +: 8] = s_w_data[8*b +: 8];
        s_b_pend = 1; s_aw_got = 0; s_w_got = 0;
      end
      bvalid = s_b_pend && !b_block;
      bresp  = s_bresp;
      if (bvalid && bready) begin s_b_pend = 0; b_count++; end
      if (s_ar_got && !s_r_pend) begin
        s_rresp = (s_ar_addr[9:8] >= 2'd2) ? s_ar_addr[9:8] : 2'b00;
        if (s_rresp != 2'b00)         s_rdata = 32'h0;
        else if (s_ar_addr[5:2] == 0) s_rdata = 32'hDEADBEEF;
        else                          s_rdata = slv_mem[s_ar_addr[5:2]];
        s_r_pend = 1; s_ar_got = 0;
      end
      rvalid = s_r_pend && !r_block;
      rdata  = s_rdata;
      rresp  = s_rresp;
      if (rvalid && rready) s_r_pend = 0;
      awready = 0;
      if (awvalid && !s_aw_got) begin
        if (s_aw_wait >= aw_delay) begin
          awready = 1; s_aw_got = 1; s_aw_addr = awaddr; s_aw_wait = 0;
        end else s_aw_wait++;
      end
      wready = 0;
      if (wvalid && !s_w_got) begin
        if (s_w_wait >= w_delay) begin
          wready = 1; s_w_got = 1; s_w_data = wdata; s_w_strb = wstrb; s_w_wait = 0;
        end else s_w_wait++;
      end
      arready = arvalid && !s_ar_got && !s_r_pend;
      if (arready) begin s_ar_got = 1; s_ar_addr = araddr; end
    end
  end

  // ---------------- compare process ----------------
  int          aw_hi = 0, w_hi = 0;
  bit          p_rsp_stall, p_aw_wait, p_w_wait, p_ar_wait;
  logic [35:0] p_rsp;
  logic [31:0] p_awaddr, p_ardr;
  logic [35:0] p_w;

  initial begin
    p_rsp_stall = 0; p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        p_rsp_stall = 0; p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0;
        continue;
      end
      if (rsp_valid) check("cmd_ready_during_rsp", cmd_ready, 0);
      if (p_rsp_stall)
        check("rsp_payload_stable", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, {1'b1, p_rsp[34:0]});
      if (p_aw_wait) check("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_w_wait)  check("w_stable", {wvalid, wdata, wstrb}, {1'b1, p_w});
      if (p_ar_wait) check("ar_stable", {arvalid, araddr}, {1'b1, p_ardr});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 64'hFFFF_FFFF_FFFF);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e[34:3]);
          check("rsp_resp", rsp_resp, e[2:1]);
          check("rsp_timeout", rsp_timeout, e[0]);
        end
      end
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      p_rsp_stall = rsp_valid && !rsp_ready;
      p_rsp       = {1'b0, rsp_rdata, rsp_resp, rsp_timeout};
      p_aw_wait   = awvalid && !awready;  p_awaddr = awaddr;
      p_w_wait    = wvalid && !wready;    p_w      = {wdata, wstrb};
      p_ar_wait   = arvalid && !arready;  p_ardr   = araddr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(output int c0, output bit ok);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    ok = cmd_ready;
    c0 = cyc;
    if (!ok) check("cmd_accept_wait", 0, 1);
  endtask

  task automatic wait_rsp(output int first, output bit ok);
    int n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    ok = rsp_valid;
    first = cyc;
    if (!ok) check("rsp_wait", 0, 1);
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int stall, input int exp_lat,
                         input bit is_to);
    int c0, first;
    bit ok;
    if (is_to) exp_q.push_back({32'h0, 2'b10, 1'b1});
    else       exp_q.push_back(model_cmd(wr, addr, data, strb));
    rsp_ready = (stall == 0);
    @(negedge clk);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
    wait_accept(c0, ok);
    if (!ok) begin cmd_valid = 0; exp_q.delete(); return; end
    @(negedge clk);
    cmd_valid = 0;
    wait_rsp(first, ok);
    if (!ok) begin exp_q.delete(); return; end
    if (exp_lat >= 0) check("rsp_latency", 64'(first - c0), 64'(exp_lat));
    repeat (stall) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  c0, first, h, b_base;
    bit  ok;
    logic [W-1:0] pin;

    // reset state
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 0);
    @(posedge clk);
    #3 rst_n = 1;
    @(negedge clk);
    check("cmd_ready_before_first_edge", cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);
    check("awprot_arprot", {awprot, arprot}, 0);

    // write then read back, zero-wait slave
    run_cmd(1, 32'h08, 32'h12345678, 4'hF, 0, 3, 0);
    check("model_pin_write", ref_mem[2], 32'h12345678);
    run_cmd(0, 32'h08, 0, 0, 0, 3, 0);
    // constant register at offset 0
    run_cmd(0, 32'h00, 0, 0, 0, 3, 0);
    // partial strobe write
    run_cmd(1, 32'h08, 32'hAABBCCDD, 4'b0101, 0, 3, 0);
    check("model_pin_strobe", ref_mem[2], 32'h12BB56DD);
    run_cmd(0, 32'h08, 0, 0, 0, 3, 0);
    // error responses passed through
    pin = model_cmd(0, 32'h204, 0, 0);
    check("model_pin_slverr", pin, {32'h0, 2'b10, 1'b0});
    run_cmd(0, 32'h204, 0, 0, 0, 3, 0);
    run_cmd(1, 32'h304, 32'h11111111, 4'hF, 0, 3, 0);

    // awready delayed 3 cycles, wready immediate
    aw_delay = 3;
    @(negedge clk);
    aw_hi = 0; w_hi = 0; b_base = b_count;
    run_cmd(1, 32'h0C, 32'hA5A50F0F, 4'hF, 0, 6, 0);
    check("awvalid_cycles", aw_hi, 4);
    check("wvalid_cycles", w_hi, 1);
    check("b_consumed", b_count - b_base, 1);
    aw_delay = 0;
    run_cmd(0, 32'h0C, 0, 0, 0, 3, 0);

    // response stall with a command waiting behind it
    rsp_ready = 0;
    exp_q.push_back(model_cmd(1, 32'h10, 32'hCAFEF00D, 4'hF));
    @(negedge clk);
    cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF; cmd_valid = 1;
    wait_accept(c0, ok);
    @(negedge clk);
    cmd_write = 0; cmd_addr = 32'h10;
    exp_q.push_back(model_cmd(0, 32'h10, 0, 0));
    wait_rsp(first, ok);
    check("stall_rsp_latency", 64'(first - c0), 3);
    repeat (10) @(negedge clk);
    rsp_ready = 1;
    h = cyc;
    @(negedge clk);
    check("b2b_accept_cycle", {cmd_ready, 32'(cyc - h)}, {1'b1, 32'd1});
    c0 = cyc;
    @(negedge clk);
    cmd_valid = 0;
    wait_rsp(first, ok);
    check("after_stall_latency", 64'(first - c0), 3);
    @(negedge clk);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // slave never answers the read until after the watchdog fires
    r_block = 1;
    run_cmd(0, 32'h08, 0, 0, 0, 17, 1);
    check("flush_holds_cmd_ready", {cmd_ready, rready}, 2'b01);
    #2 r_block = 0;
    begin
      int n = 0;
      while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    end
    check("flush_done_cmd_ready", cmd_ready, 1);
    check("flush_no_rsp", rsp_valid, 0);
    run_cmd(0, 32'h08, 0, 0, 0, 3, 0);
`endif

    // reset while waiting for B
    b_block = 1;
    @(negedge clk);
    cmd_write = 1; cmd_addr = 32'h14; cmd_wdata = 32'h55; cmd_wstrb = 4'hF; cmd_valid = 1;
    wait_accept(c0, ok);
    @(negedge clk);
    cmd_valid = 0;
    begin
      int n = 0;
      while (!bready && n < 20) begin @(negedge clk); n++; end
    end
    check("reached_wr_b", bready, 1);
    @(posedge clk);
    #3 rst_n = 0;
    #1 check("mid_txn_reset_outputs",
             {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 0);
    repeat (2) @(negedge clk);
    b_block = 0;
    @(posedge clk);
    #3 rst_n = 1;
    @(negedge clk);
    check("post_reset_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    check("post_reset_cmd_ready_high", cmd_ready, 1);
    run_cmd(1, 32'h18, 32'h0BADF00D, 4'hF, 0, 3, 0);
    run_cmd(0, 32'h18, 0, 0, 0, 3, 0);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

AXI4-Lite master that turns single-beat command requests into AXI4-Lite read or write transactions and returns one response per command. It is the initiator counterpart to the design's AXI4-Lite slave register files. It lets on-chip logic, such as a test sequencer or an init engine, program register blocks on the same interconnect as the PCIe bridge. Only one transaction is outstanding at a time.

## Interface
- C_M_AXI_DATA_WIDTH, 32, data width; wstrb width = C_M_AXI_DATA_WIDTH/8
- C_M_AXI_ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 1024, watchdog limit in clocks; used only with the macro
- M_AXI_ACLK  in  1  sole clock
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR  byte address
- cmd_wdata, cmd_wstrb  in  DATA, DATA/8  write payload
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  DATA  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP as received
- rsp_timeout  out  1  watchdog fired
- M_AXI_AW*, W*, B*, AR*, R*  full AXI4-Lite master channels
  - awprot/arprot tied to 3'b000

## Operation
- States: IDLE, WR (AW+W), WR_B, RD_AR, RD_R, RSP, FLUSH.
- cmd_ready = (state == IDLE); it is decoded from the registered state.
- On a cmd handshake, addr/data/strb/write are registered.
- Write path:
  - IDLE → WR: awvalid and wvalid both assert.
  - Each valid deasserts independently on its own handshake; either order is legal, including the same cycle.
  - When both are done → WR_B with bready = 1.
  - On bvalid: capture bresp → RSP.
- Read path:
  - IDLE → RD_AR: arvalid = 1. On arready → RD_R with rready = 1.
  - On rvalid: capture rdata and rresp → RSP.
- RSP:
  - rsp_valid = 1; payload is held stable until rsp_ready.
  - On handshake → IDLE.
  - rsp_ready low stalls indefinitely; no new command is accepted during the stall.
- Valid signals never drop before their ready (AXI rule). Addresses and data stay stable while valid.
- Responses are passed through unmodified: SLVERR and DECERR are reported, not retried.
- Reset (any time, including mid-transaction):
  - All valids/readies, rsp_* and cmd_ready = 0 while asserted; state = IDLE.
  - cmd_ready rises the first cycle after deassertion.
  - An in-flight AXI transaction is abandoned; slaves share ARESETN.

## Timing
- Zero-wait slave, write:
  - cmd accepted at cycle 0; aw/wvalid at 1; bready at 2.
  - bvalid at 2 gives rsp_valid at 3.
- Zero-wait slave, read: arvalid at 1, rready at 2, rsp_valid at 3.
- Back-to-back: the next cmd is accepted the cycle after the rsp handshake. Minimum is 4 cycles per command.
- All AXI outputs and rsp_* are registered; no combinational path from AXI inputs to AXI outputs.

## Configuration
- AXIL_CMD_MASTER_TIMEOUT_EN defined:
  - A counter clears on cmd accept and increments in WR, WR_B, RD_AR and RD_R.
  - When it reaches TIMEOUT_CYCLES: enter RSP with rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
  - After the rsp handshake → FLUSH. FLUSH keeps pending valids asserted and bready/rready = 1 until the transaction completes, discards the result, then → IDLE.
- Undefined:
  - No counter and no FLUSH state.
  - rsp_timeout is tied 0; waits are unbounded.

## Structure
- Package axil_cmd_master_pkg holds:
  - state enum
  - localparams RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11
- Sub-module axil_cmd_watchdog:
  - Holds the counter; width $clog2(TIMEOUT_CYCLES+1).
  - Ports clr/en/expired.
  - Instantiated only under the macro.

## Test plan
- Write 0x12345678, strb 0xF, addr 0x08 to a slave regfile, then read 0x08 → rsp_rdata = 0x12345678, rsp_resp = 0 both times; rsp_valid at cycle 3 each.
- Read addr 0x00 of a regfile returning constant 0xDEADBEEF → rsp_rdata = 0xDEADBEEF.
- Write with awready delayed 3 cycles and wready immediate:
  - wvalid drops after 1 cycle; awvalid is held 4 cycles.
  - awaddr is stable throughout; exactly one B is consumed.
- Hold rsp_ready = 0 for 10 cycles with cmd_valid = 1 → cmd_ready stays 0; the payload is stable; the next command is accepted the cycle after the handshake.
- Macro on, TIMEOUT_CYCLES = 16, slave never asserts rvalid:
  - rsp_timeout = 1 and rsp_resp = 2'b10 at cycle 17.
  - A late rvalid in FLUSH is absorbed; then cmd_ready = 1.
- Assert ARESETN low while in WR_B → all valids = 0 immediately; after release, cmd_ready = 1 and a fresh write completes normally.
